// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the dual H-bridge PWM motor driver.
// spd_mag folds a signed speed command into an 11-bit duty magnitude.
package mtr_drv_pkg;

  localparam int PWM_W  = 11;
  localparam int PERIOD = 2048;

  typedef logic signed [11:0] spd_t;
  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PERIOD - 1);

  // -2048 has no 11-bit magnitude, so it saturates to full scale.
  function automatic logic [PWM_W-1:0] spd_mag(input spd_t spd);
    logic [11:0] raw;
    logic [11:0] abs_v;
    raw = spd;
    if (raw == 12'h800) begin
      spd_mag = {PWM_W{1'b1}};
    end else begin
      abs_v   = raw[11] ? (~raw + 12'd1) : raw;
      spd_mag = abs_v[PWM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_pair.sv
// One motor's forward/reverse PWM pair: period-boundary latching of duty and
// direction, direction-change dead time, registered outputs, shutdown masking.
module mtr_drv_pwm_pair
  import mtr_drv_pkg::*;
#(
  parameter int DEAD = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt,
  input  spd_t             spd,
  input  logic             shtdwn,
  output logic             frwrd,
  output logic             rev
);

  localparam logic [PWM_W-1:0] DEAD_C = PWM_W'(DEAD);

  logic [PWM_W-1:0] duty_q;
  dir_t             dir_q;
  dir_t             dir_new;
  logic             dead_q;
  logic             frwrd_q;
  logic             rev_q;
  logic             on;

  assign dir_new = spd[11] ? REV : FWD;
  // Dead time only gates the start of a period whose direction just flipped.
  assign on      = (cnt < duty_q) && !(dead_q && (cnt < DEAD_C));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q  <= '0;
      dir_q   <= FWD;
      dead_q  <= 1'b0;
      frwrd_q <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      frwrd_q <= on && (dir_q == FWD);
      rev_q   <= on && (dir_q == REV);
      if (cnt == CNT_LAST) begin
        duty_q <= spd_mag(spd);
        dir_q  <= dir_new;
        dead_q <= (dir_new != dir_q);
      end
    end
  end

  assign frwrd = frwrd_q & ~shtdwn;
  assign rev   = rev_q & ~shtdwn;

endmodule

// File: rtl/mtr_drv.sv
// Dual motor driver top: shared period counter, overcurrent synchronizers,
// blanking-window qualification, consecutive-period counter and sticky shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int DEAD      = 32,
  parameter int BLANK     = 128,
  parameter int OVR_LIMIT = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  spd_t lft_spd,
  input  spd_t rght_spd,
  input  logic OVR_I_lft,
  input  logic OVR_I_rght,
  output logic PWM_frwrd_lft,
  output logic PWM_rev_lft,
  output logic PWM_frwrd_rght,
  output logic PWM_rev_rght,
  output logic OVR_I_shtdwn
);

  localparam int               OCW     = $clog2(OVR_LIMIT + 1);
  localparam logic [OCW-1:0]   OVR_MAX = OCW'(OVR_LIMIT);
  localparam logic [PWM_W-1:0] BLANK_C = PWM_W'(BLANK);

  logic [PWM_W-1:0] cnt;
  logic [1:0]       sync_lft;
  logic [1:0]       sync_rght;
  logic             ovr;
  logic             pwm_any;
  logic             qual;
  logic             ovr_seen;
  logic             ovr_hit;
  logic [OCW-1:0]   ovr_cnt;
  logic             shtdwn_q;

  assign ovr     = sync_lft[1] | sync_rght[1];
  assign pwm_any = PWM_frwrd_lft | PWM_rev_lft | PWM_frwrd_rght | PWM_rev_rght;
  // Overcurrent only counts once switching transients have settled.
  assign qual    = ovr && (cnt >= BLANK_C) && pwm_any;
  assign ovr_hit = ovr_seen | qual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sync_lft  <= '0;
      sync_rght <= '0;
      ovr_seen  <= 1'b0;
      ovr_cnt   <= '0;
      shtdwn_q  <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      sync_lft  <= {sync_lft[0], OVR_I_lft};
      sync_rght <= {sync_rght[0], OVR_I_rght};
      ovr_seen  <= (cnt == '0) ? qual : (ovr_seen | qual);
      if (cnt == CNT_LAST) begin
        if (!ovr_hit)                ovr_cnt <= '0;
        else if (ovr_cnt != OVR_MAX) ovr_cnt <= ovr_cnt + 1'b1;
      end
      if (ovr_cnt == OVR_MAX) shtdwn_q <= 1'b1;
    end
  end

  assign OVR_I_shtdwn = shtdwn_q;

  mtr_drv_pwm_pair #(.DEAD(DEAD)) u_lft (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt    (cnt),
    .spd    (lft_spd),
    .shtdwn (shtdwn_q),
    .frwrd  (PWM_frwrd_lft),
    .rev    (PWM_rev_lft)
  );

  mtr_drv_pwm_pair #(.DEAD(DEAD)) u_rght (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt    (cnt),
    .spd    (rght_spd),
    .shtdwn (shtdwn_q),
    .frwrd  (PWM_frwrd_rght),
    .rev    (PWM_rev_rght)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: counts PWM high clocks per 2048-clock period
// and checks duty, direction, dead time, blanking and the shutdown counter.
module tb_mtr_drv;

  logic               clk;
  logic               rst_n;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               OVR_I_lft;
  logic               OVR_I_rght;
  logic               PWM_frwrd_lft;
  logic               PWM_rev_lft;
  logic               PWM_frwrd_rght;
  logic               PWM_rev_rght;
  logic               OVR_I_shtdwn;

  int n_checks = 0;
  int n_fail   = 0;

  // per-period measurements
  int   hf_l, hr_l, hf_r, hr_r, both;
  int   first_rev_l, last_rev_l;
  logic sd0, sd1, sd_end;

  logic [10:0] m_cnt;

  // A short limit keeps the shutdown scenarios within a small cycle budget.
  mtr_drv #(.DEAD(32), .BLANK(128), .OVR_LIMIT(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lft_spd        (lft_spd),
    .rght_spd       (rght_spd),
    .OVR_I_lft      (OVR_I_lft),
    .OVR_I_rght     (OVR_I_rght),
    .PWM_frwrd_lft  (PWM_frwrd_lft),
    .PWM_rev_lft    (PWM_rev_lft),
    .PWM_frwrd_rght (PWM_frwrd_rght),
    .PWM_rev_rght   (PWM_rev_rght),
    .OVR_I_shtdwn   (OVR_I_shtdwn)
  );

  // clock / reset-tracking counter model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= '0;
    else        m_cnt <= m_cnt + 11'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full period sampled on negedges from cnt==0; ovr_mode: 0 quiet,
  // 1 left pulse in the first 100 clocks, 2 left held, 3 right held.
  task automatic measure(input int chg_at, input logic signed [11:0] new_lft, input int ovr_mode);
    int guard;
    guard = 0;
    while (m_cnt != 11'd0 && guard < 4096) begin
      @(negedge clk);
      guard++;
    end
    hf_l = 0; hr_l = 0; hf_r = 0; hr_r = 0; both = 0;
    first_rev_l = -1; last_rev_l = -1;
    sd0 = 1'bx; sd1 = 1'bx; sd_end = 1'bx;
    for (int k = 0; k < 2048; k++) begin
      if (k == chg_at) lft_spd = new_lft;
      case (ovr_mode)
        1:       begin OVR_I_lft = (k < 100); OVR_I_rght = 1'b0; end
        2:       begin OVR_I_lft = 1'b1;      OVR_I_rght = 1'b0; end
        3:       begin OVR_I_lft = 1'b0;      OVR_I_rght = 1'b1; end
        default: begin OVR_I_lft = 1'b0;      OVR_I_rght = 1'b0; end
      endcase
      if (PWM_frwrd_lft)  hf_l++;
      if (PWM_frwrd_rght) hf_r++;
      if (PWM_rev_rght)   hr_r++;
      if (PWM_rev_lft) begin
        hr_l++;
        if (first_rev_l < 0) first_rev_l = k;
        last_rev_l = k;
      end
      if ((PWM_frwrd_lft && PWM_rev_lft) || (PWM_frwrd_rght && PWM_rev_rght)) both++;
      if (k == 0)    sd0    = OVR_I_shtdwn;
      if (k == 1)    sd1    = OVR_I_shtdwn;
      if (k == 2047) sd_end = OVR_I_shtdwn;
      @(negedge clk);
    end
  endtask

  initial begin
    int guard;
    rst_n      = 1'b0;
    lft_spd    = 12'sd512;
    rght_spd   = -12'sd2048;
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_frwrd_lft",  PWM_frwrd_lft,  0);
    check("rst_rev_lft",    PWM_rev_lft,    0);
    check("rst_frwrd_rght", PWM_frwrd_rght, 0);
    check("rst_rev_rght",   PWM_rev_rght,   0);
    check("rst_shtdwn",     OVR_I_shtdwn,   0);
    rst_n = 1'b1;

    // first period after reset runs at duty 0
    measure(-1, 12'sd0, 0);
    check("p0_frwrd_lft", hf_l, 0);
    check("p0_rev_rght",  hr_r, 0);

    // +512 left, -2048 right (right flips from reset FWD, so dead time)
    measure(-1, 12'sd0, 0);
    check("p1_frwrd_lft", hf_l, 512);
    check("p1_rev_lft",   hr_l, 0);
    check("p1_rev_rght",  hr_r, 2015);
    check("p1_frwrd_rght", hf_r, 0);
    check("p1_both",      both, 0);
    measure(-1, 12'sd0, 0);
    check("p2_frwrd_lft", hf_l, 512);
    check("p2_rev_rght",  hr_r, 2047);

    // direction change: +1000 then -1000 mid-period
    lft_spd = 12'sd1000;
    measure(-1, 12'sd0, 0);
    check("p3_frwrd_lft", hf_l, 512);
    measure(1024, -12'sd1000, 0);
    check("p4_frwrd_lft", hf_l, 1000);
    check("p4_rev_lft",   hr_l, 0);
    measure(-1, 12'sd0, 0);
    check("p5_frwrd_lft", hf_l, 0);
    check("p5_rev_lft",   hr_l, 968);
    check("p5_rev_first", first_rev_l, 33);
    check("p5_rev_last",  last_rev_l, 1000);
    check("p5_both",      both, 0);
    measure(-1, 12'sd0, 0);
    check("p6_rev_lft",   hr_l, 1000);
    check("p6_rev_first", first_rev_l, 1);

    // overcurrent pulses inside the blanking window never qualify
    lft_spd = 12'sd1500;
    measure(-1, 12'sd0, 1);
    check("p7_rev_lft",   hr_l, 1000);
    measure(-1, 12'sd0, 1);
    check("p8_frwrd_lft", hf_l, 1468);
    for (int i = 0; i < 5; i++) begin
      measure(-1, 12'sd0, 1);
      check("blank_frwrd_lft", hf_l, 1500);
      check("blank_shtdwn",    sd_end, 0);
    end

    // burst one short of the limit, then a clean period clears the count
    for (int i = 0; i < 4; i++) begin
      measure(-1, 12'sd0, 2);
      check("burst_shtdwn",    sd_end, 0);
      check("burst_frwrd_lft", hf_l, 1500);
    end
    measure(-1, 12'sd0, 0);
    check("clean_shtdwn", sd_end, 0);

    // right overcurrent held: limit reached after five periods
    for (int i = 0; i < 5; i++) begin
      measure(-1, 12'sd0, 3);
      check("hold_shtdwn", sd_end, 0);
    end
    measure(-1, 12'sd0, 3);
    check("sd_cnt0",       sd0, 0);
    check("sd_cnt1",       sd1, 1);
    check("sd_frwrd_lft",  hf_l, 0);
    check("sd_rev_rght",   hr_r, 0);
    check("sd_end",        sd_end, 1);

    // asynchronous reset mid-period while shut down
    guard = 0;
    while (m_cnt != 11'd700 && guard < 4096) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_shtdwn",    OVR_I_shtdwn,   0);
    check("mid_rst_frwrd_lft", PWM_frwrd_lft,  0);
    check("mid_rst_rev_rght",  PWM_rev_rght,   0);
    OVR_I_rght = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure(-1, 12'sd0, 0);
    check("post_p0_frwrd_lft", hf_l, 0);
    check("post_p0_rev_rght",  hr_r, 0);
    check("post_p0_shtdwn",    sd_end, 0);
    measure(-1, 12'sd0, 0);
    check("post_p1_frwrd_lft", hf_l, 1500);
    check("post_p1_rev_rght",  hr_r, 2015);
    check("post_p1_shtdwn",    sd_end, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
